// File: rtl/mem_burst_master_if.sv
// Command, write-stream, read-stream and scratch-memory signals of mem_burst_master.
// The master modport is the controller's view; slave is the environment's view.
interface mem_burst_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_burst_master.sv
// Burst controller for the 32x8 scratch memory: streams write beats in and read
// beats out, absorbing the one-cycle read latency with a 2-entry buffer.
module mem_burst_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  mem_burst_master_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W:0]   beats;
  logic              inflight;
  logic              done_q;
  logic [DATA_W-1:0] fifo [2];
  logic              wp;
  logic              rp;
  logic [1:0]        count;

  logic              wr_hs;
  logic              pop;
  logic              rd_issue;
  logic              last_rd;
  logic [2:0]        occ;

  always_comb begin
    wr_hs    = (state == WR) && bus.wr_valid;
    pop      = (count != 2'd0) && bus.rd_ready;
    // Buffer slots still claimed after this cycle's pop; keep at most two.
    occ      = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    rd_issue = (state == RD) && (beats != '0) && (occ < 3'd2);
    last_rd  = (state == RD) && pop && (count == 2'd1) && !inflight && (beats == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      beats    <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      fifo     <= '{default: '0};
      wp       <= 1'b0;
      rp       <= 1'b0;
      count    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cur_addr <= bus.cmd_addr;
            beats    <= {1'b0, bus.cmd_len} + (ADDR_W+1)'(1);
            state    <= bus.cmd_write ? WR : RD;
          end
        end
        WR: begin
          if (wr_hs) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            beats    <= beats - (ADDR_W+1)'(1);
            addr_q   <= cur_addr;
            wdata_q  <= bus.wr_data;
            if (beats == (ADDR_W+1)'(1)) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        RD: begin
          if (rd_issue) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            beats    <= beats - (ADDR_W+1)'(1);
            addr_q   <= cur_addr;
          end
          if (last_rd) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      inflight <= rd_issue;
      if (inflight) begin
        fifo[wp] <= bus.mem_rdata;
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Address and write data follow the live values only while a strobe is up.
  assign bus.mem_write = wr_hs;
  assign bus.mem_read  = rd_issue;
  assign bus.mem_addr  = (wr_hs || rd_issue) ? cur_addr : addr_q;
  assign bus.mem_wdata = wr_hs ? bus.wr_data : wdata_q;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WR);
  assign bus.rd_valid  = (count != 2'd0);
  assign bus.rd_data   = fifo[rp];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a 32x8 registered-read memory model
// and a negedge monitor logging strobes, delivered beats and done pulses.
module tb_mem_burst_master;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic clk;
  logic rst;

  mem_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DATA_W-1:0] mem [32];
  always @(posedge clk) begin
    if (bus.mem_write && !bus.mem_read) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read && !bus.mem_write) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned wr_cyc[$], wr_addr[$], wr_dat[$];
  int unsigned rd_cyc[$], rd_addr[$];
  int unsigned bt_cyc[$], bt_dat[$];
  int unsigned dn_cyc[$];
  int unsigned both_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem_write) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(32'(bus.mem_addr));
      wr_dat.push_back(32'(bus.mem_wdata));
    end
    if (bus.mem_read) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(32'(bus.mem_addr));
    end
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if (bus.rd_valid && bus.rd_ready) begin
      bt_cyc.push_back(cyc);
      bt_dat.push_back(32'(bus.rd_data));
    end
    if (bus.done) dn_cyc.push_back(cyc);
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned acc      = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned at(input int unsigned q[$], input int unsigned i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
    rd_cyc.delete(); rd_addr.delete();
    bt_cyc.delete(); bt_dat.delete();
    dn_cyc.delete();
  endtask

  task automatic issue(input logic w, input int unsigned a, input int unsigned l);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = ADDR_W'(a);
    bus.cmd_len   = ADDR_W'(l);
    @(negedge clk);
    acc = cyc;
    check_eq("cmd_ready", 32'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    for (int unsigned n = 0; n < budget && dn_cyc.size() == 0; n++) tick();
    check_eq("done_seen", 32'(dn_cyc.size() != 0), 1);
  endtask

  int unsigned ea[4];
  int unsigned stall;
  int unsigned st_cyc;
  int unsigned cnt;

  initial begin
    rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid  = 1'b0; bus.wr_data   = '0;   bus.rd_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int unsigned i = 0; i < 32; i++) mem[i] = '0;

    // Reset asserted mid-cycle
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_busy",      32'(bus.busy), 0);
    check_eq("rst_rd_valid",  32'(bus.rd_valid), 0);
    check_eq("rst_wr_ready",  32'(bus.wr_ready), 0);
    check_eq("rst_mem_read",  32'(bus.mem_read), 0);
    check_eq("rst_mem_write", 32'(bus.mem_write), 0);
    check_eq("rst_mem_addr",  32'(bus.mem_addr), 0);
    check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check_eq("rst_done",      32'(bus.done), 0);
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    tick();
    rst = 1'b0;
    clear_logs();
    for (int unsigned i = 0; i < 5; i++) tick();
    check_eq("idle_strobes", wr_cyc.size() + rd_cyc.size(), 0);

    // Write burst 30..1 with wrap
    ea = '{30, 31, 0, 1};
    clear_logs();
    issue(1'b1, 30, 3);
    for (int unsigned i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = DATA_W'(32'hA0 + i);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick(); tick();
    check_eq("wr_count", wr_cyc.size(), 4);
    for (int unsigned i = 0; i < 4; i++) begin
      check_eq("wr_addr", at(wr_addr, i), ea[i]);
      check_eq("wr_data", at(wr_dat, i), 32'hA0 + i);
      check_eq("wr_cycle", at(wr_cyc, i), acc + 1 + i);
      check_eq("wr_mem", 32'(mem[ea[i]]), 32'hA0 + i);
    end
    check_eq("wr_done_cyc", at(dn_cyc, 0), acc + 5);
    check_eq("wr_done_once", dn_cyc.size(), 1);

    // Read burst 30..1 with rd_ready high
    bus.rd_ready = 1'b1;
    clear_logs();
    issue(1'b0, 30, 3);
    wait_done(20);
    tick();
    check_eq("rd_reads", rd_cyc.size(), 4);
    check_eq("rd_beats", bt_cyc.size(), 4);
    for (int unsigned i = 0; i < 4; i++) begin
      check_eq("rd_addr", at(rd_addr, i), ea[i]);
      check_eq("rd_issue_cyc", at(rd_cyc, i), acc + 1 + i);
      check_eq("rd_beat_cyc", at(bt_cyc, i), acc + 3 + i);
      check_eq("rd_data", at(bt_dat, i), 32'hA0 + i);
    end
    check_eq("rd_done_cyc", at(dn_cyc, 0), acc + 7);
    check_eq("rd_busy_after", 32'(bus.busy), 0);

    // Backpressured 8-beat read of 8..15
    clear_logs();
    issue(1'b1, 8, 7);
    for (int unsigned i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = DATA_W'(32'h10 + i);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick(); tick();
    clear_logs();
    issue(1'b0, 8, 7);
    stall = 0;
    st_cyc = 0;
    for (int unsigned n = 0; n < 40 && dn_cyc.size() == 0; n++) begin
      if (bt_dat.size() >= 2 && stall < 6) begin
        bus.rd_ready = 1'b0;
        if (stall == 0) st_cyc = cyc;
        stall++;
      end else begin
        bus.rd_ready = 1'b1;
      end
      @(negedge clk);
      if (!bus.rd_ready) begin
        check_eq("bp_valid_hold", 32'(bus.rd_valid), 1);
        check_eq("bp_data_hold", 32'(bus.rd_data), 32'h12);
      end
      tick();
    end
    bus.rd_ready = 1'b1;
    check_eq("bp_done_seen", 32'(dn_cyc.size() != 0), 1);
    check_eq("bp_stall_start", st_cyc, acc + 5);
    check_eq("bp_beats", bt_dat.size(), 8);
    check_eq("bp_reads", rd_cyc.size(), 8);
    for (int unsigned i = 0; i < 8; i++) begin
      check_eq("bp_data", at(bt_dat, i), 32'h10 + i);
      check_eq("bp_addr", at(rd_addr, i), 8 + i);
    end
    cnt = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] < st_cyc) cnt++;
    check_eq("bp_reads_before_stall", cnt, 4);
    cnt = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] >= st_cyc && rd_cyc[i] <= st_cyc + 5) cnt++;
    check_eq("bp_reads_in_stall", cnt, 0);
    cnt = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] == st_cyc + 6) cnt++;
    check_eq("bp_read_resume", cnt, 1);
    tick();

    // Write with wr_valid gaps: 1,0,1,0,1
    clear_logs();
    issue(1'b1, 20, 2);
    for (int unsigned i = 0; i < 5; i++) begin
      bus.wr_valid = (i % 2 == 0);
      bus.wr_data  = DATA_W'(32'hB0 + i / 2);
      tick();
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check_eq("gap_wr_ready", 32'(bus.wr_ready), 0);
    check_eq("gap_done", 32'(bus.done), 1);
    tick();
    check_eq("gap_count", wr_cyc.size(), 3);
    for (int unsigned i = 0; i < 3; i++) begin
      check_eq("gap_addr", at(wr_addr, i), 20 + i);
      check_eq("gap_cyc", at(wr_cyc, i), acc + 1 + 2 * i);
      check_eq("gap_data", at(wr_dat, i), 32'hB0 + i);
    end

    // Reset during a 16-beat read, then a fresh 1-beat read of address 0
    clear_logs();
    issue(1'b0, 0, 15);
    for (int unsigned n = 0; n < 20 && bt_dat.size() < 5; n++) tick();
    check_eq("abort_beats", bt_dat.size(), 5);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_rd_valid", 32'(bus.rd_valid), 0);
    check_eq("abort_mem_read", 32'(bus.mem_read), 0);
    check_eq("abort_busy", 32'(bus.busy), 0);
    tick();
    rst = 1'b0;
    tick();
    clear_logs();
    issue(1'b0, 0, 0);
    wait_done(10);
    check_eq("post_rst_beats", bt_dat.size(), 1);
    check_eq("post_rst_data", at(bt_dat, 0), 32'hA2);
    check_eq("post_rst_addr", at(rd_addr, 0), 0);
    tick();

    check_eq("strobe_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator-side controller for the team's 32x8 synchronous scratch memory (read/write strobes, 5-bit address, 8-bit data, registered read data).
- Accepts burst commands: op, start address, beat count.
- Streams write data in and read data out through valid/ready handshakes.
- Generates legal, never-simultaneous memory strobes and absorbs the one-cycle read latency with a 2-entry output buffer.

Parameters:
- ADDR_W, 5, memory address width; addresses wrap modulo 2**ADDR_W.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  ADDR_W  burst start address.
- cmd_len  input  ADDR_W  beats minus one (0 -> 1 beat, 31 -> 32 beats).
- wr_valid  input  1  write data beat valid.
- wr_ready  output  1  controller accepts write beat.
- wr_data  input  DATA_W  write beat data.
- rd_valid  output  1  read beat available.
- rd_ready  input  1  consumer accepts read beat.
- rd_data  output  DATA_W  read beat data.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory registered read data, valid the cycle after a sampled mem_read.

Behaviour:
- FSM states: IDLE, WR, RD.
- Reset values (async, immediate): state IDLE; cur_addr 0; beat counters 0; inflight 0; FIFO empty; done 0. Resulting outputs: busy 0, rd_valid 0, wr_ready 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, cmd_ready 1.
- IDLE:
  - cmd_ready=1.
  - On accept: latch cur_addr=cmd_addr and beats=cmd_len+1 (ADDR_W+1 bits).
  - Go to WR if cmd_write, else RD.
- WR:
  - wr_ready=1.
  - mem_write = wr_valid (combinational); mem_addr=cur_addr; mem_wdata=wr_data.
  - Each wr handshake: cur_addr+1 (wraps 31->0), beats-1.
  - Last handshake: next state IDLE, done=1 the following cycle.
  - wr_valid gaps: no strobe, no address advance.
- RD issue rule:
  - mem_read=1 iff issue_left>0 && (fifo_count + inflight - pop) < 2.
  - pop = rd_valid && rd_ready.
  - mem_addr=cur_addr; each issued read advances cur_addr (wraps) and decrements issue_left.
- RD capture:
  - inflight register = mem_read of previous cycle.
  - When inflight=1, push mem_rdata into 2-entry FIFO at end of that cycle.
- RD output:
  - rd_valid = FIFO non-empty; rd_data = FIFO head, stable while rd_valid && !rd_ready.
  - Order preserved.
- RD timing: first rd_valid two cycles after first mem_read cycle. With rd_ready held high, one beat per cycle sustained.
- RD exit: IDLE in the cycle after the last pop with issue_left=0 and inflight=0; done pulses that cycle.
- busy = state != IDLE.
- mem_read and mem_write are never 1 in the same cycle (the memory ignores both when both are asserted); enforced structurally by state.
- mem_addr/mem_wdata hold their last values when no strobe is asserted.
- A new command may be accepted in the same cycle done is high.
- Reset mid-burst aborts the burst:
  - Strobes drop immediately.
  - FIFO contents and the in-flight beat are discarded.
  - Memory contents are not altered beyond already-completed writes.
- cmd_len=31 covers all 32 locations with wrap back to the start address; no error condition exists.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately except cmd_ready=1; release, idle 5 cycles -> no strobes.
- Write burst, cmd_addr=30, cmd_len=3, wr_data A0,A1,A2,A3, wr_valid continuous -> mem_write on 4 consecutive cycles at addrs 30,31,0,1; done one cycle later; memory model holds A0..A3.
- Read burst, cmd_addr=30, cmd_len=3, rd_ready=1 -> mem_read at 30,31,0,1 on consecutive cycles; rd_data A0,A1,A2,A3 on 4 consecutive rd_valid cycles starting 2 cycles after first mem_read; done after last beat; busy 0.
- Backpressure, 8-beat read, rd_ready low for 6 cycles after beat 2 -> mem_read stalls once FIFO+inflight=2; no beat lost or duplicated; order intact; mem_read/mem_write never both high.
- Write with wr_valid toggling 1,0,1,0,1 for 3 beats -> exactly 3 mem_write cycles, addresses consecutive, wr_ready low after last beat.
- rst asserted during 16-beat read after 5 beats delivered -> rd_valid, mem_read, busy drop immediately; new 1-beat read of addr 0 after release returns A2.
